// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the RV32I multicycle sequencer: states, opcodes,
// datapath select codes and ALU operation codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_JMP, S_LUI, S_AUIPC
  } state_t;

  typedef enum logic [1:0] {OPC_R, OPC_I, OPC_BR} opclass_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_U    = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_B    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Even funct3 tests the flag directly, odd funct3 tests its complement.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt);
    return funct3[2] ? (lt ^ funct3[0]) : (zero ^ funct3[0]);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the sequencer (master) and the shared datapath
// plus memory port (slave).
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic        lt;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic        illegal;
  logic        bus_err;

  modport master (
    input  instr, zero, lt, mem_ack,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal, bus_err
  );

  modport slave (
    output instr, zero, lt, mem_ack,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps instruction class and funct fields to an ALU operation for the
// register, immediate and branch execute states.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  opclass_t   opclass,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (opclass == OPC_BR) begin
      // Reserved branch funct3 (01x) falls through to ADD; the FSM flags it.
      case (funct3[2:1])
        2'b00:   alu_ctrl = ALU_SUB;
        2'b10:   alu_ctrl = ALU_SLT;
        2'b11:   alu_ctrl = ALU_SLTU;
        default: alu_ctrl = ALU_ADD;
      endcase
    end else begin
      // ADDI has no SUB form, so bit 30 only matters for R-type at funct3 000.
      case (funct3)
        3'b000:  alu_ctrl = (opclass == OPC_R && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b011:  alu_ctrl = ALU_SLTU;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// RV32I multicycle sequencer: steps the shared datapath through fetch, decode,
// execute, memory and writeback, with a watchdog on the memory handshake.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] wd_cnt;
  logic          waiting, wd_expire;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  opclass_t      opclass;
  logic [3:0]    dec_alu;
  logic          unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  assign opclass      = (state == S_EXECR) ? OPC_R : (state == S_BRANCH) ? OPC_BR : OPC_I;

  assign waiting   = state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign wd_expire = (TIMEOUT != 0) && waiting && !bus.mem_ack &&
                     (wd_cnt == CW'(TIMEOUT - 1));

  alu_decoder u_alu_decoder (
    .opclass  (opclass),
    .funct3   (funct3),
    .funct7_5 (bus.instr[30]),
    .alu_ctrl (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      wd_cnt <= '0;
    end else begin
      state <= state_nx;
      // Expiry returns FETCH to itself, so it must clear the count explicitly.
      if (waiting && !bus.mem_ack && !wd_expire && state_nx == state)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
    end
  end

  always_comb begin
    state_nx       = state;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RD2;
    bus.result_src = RES_ALUOUT;
    bus.imm_src    = IMM_NONE;
    bus.alu_ctrl   = ALU_ADD;
    bus.illegal    = 1'b0;
    bus.bus_err    = 1'b0;

    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_write   = 1'b1;
          bus.pc_write   = 1'b1;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALU;
          state_nx       = S_DECODE;
        end else if (wd_expire) begin
          bus.mem_req = 1'b0;
          bus.bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        // ALUOut captures the branch/jump target while the opcode dispatches.
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXECR;
          OP_I:              state_nx = S_EXECI;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR_ADR;
          OP_LUI:            state_nx = S_LUI;
          OP_AUIPC:          state_nx = S_AUIPC;
          default: begin
            bus.illegal = 1'b1;
            state_nx    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = SRCA_RD1;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_nx      = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ack) begin
          state_nx = S_MEMWB;
        end else if (wd_expire) begin
          bus.mem_req = 1'b0;
          bus.bus_err = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      S_MEMWB: begin
        bus.result_src = RES_MEM;
        bus.reg_write  = 1'b1;
        state_nx       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ack) begin
          state_nx = S_FETCH;
        end else if (wd_expire) begin
          bus.mem_req = 1'b0;
          bus.mem_we  = 1'b0;
          bus.bus_err = 1'b1;
          state_nx    = S_FETCH;
        end
      end
      S_EXECR: begin
        bus.alu_src_a = SRCA_RD1;
        bus.alu_ctrl  = dec_alu;
        state_nx      = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a = SRCA_RD1;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = IMM_I;
        bus.alu_ctrl  = dec_alu;
        state_nx      = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_nx      = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a = SRCA_RD1;
        bus.alu_ctrl  = dec_alu;
        if (funct3[2:1] == 2'b01) bus.illegal  = 1'b1;
        else                      bus.pc_write = branch_taken(funct3, bus.zero, bus.lt);
        state_nx = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_write  = 1'b1;
        state_nx      = S_ALUWB;
      end
      S_JALR_ADR: begin
        bus.alu_src_a = SRCA_RD1;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = IMM_I;
        state_nx      = S_JALR_JMP;
      end
      S_JALR_JMP: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_write  = 1'b1;
        state_nx      = S_ALUWB;
      end
      S_LUI: begin
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = IMM_U;
        bus.alu_ctrl  = ALU_PASSB;
        state_nx      = S_ALUWB;
      end
      S_AUIPC: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = IMM_U;
        state_nx      = S_ALUWB;
      end
      default: state_nx = S_FETCH;
    endcase

    // Reset abandons any request in the same cycle.
    if (rst) begin
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.adr_src    = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.result_src = 2'b00;
      bus.imm_src    = 3'b000;
      bus.alu_ctrl   = 4'd0;
      bus.illegal    = 1'b0;
      bus.bus_err    = 1'b0;
    end
  end

endmodule
